// File: rtl/trunc_pkg.sv
// Shared types for the truncation arbiter: datapath widths and the FIFO entry layout.
package trunc_pkg;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 5;

   typedef logic [LEN_W-1:0]  len_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef struct packed {
      data_t data;
      logic  id;
   } entry_t;

endpackage

// File: rtl/trunc_mask.sv
// Combinational low-bit truncation: keeps data[len-1:0] and always clears the top bit.
module trunc_mask
   import trunc_pkg::*;
#(
   parameter int DATA_W = trunc_pkg::DATA_W,
   parameter int LEN_W  = trunc_pkg::LEN_W
) (
   input  logic [LEN_W-1:0]  len_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o
);

   logic [DATA_W-1:0] keep;
   logic [DATA_W-1:0] top_clr;

   // len never exceeds DATA_W-1, so the shift cannot overflow the word.
   assign keep    = (DATA_W'(1) << len_i) - DATA_W'(1);
   assign top_clr = {1'b0, {(DATA_W-1){1'b1}}};
   assign data_o  = data_i & keep & top_clr;

endmodule

// File: rtl/trunc_arbiter.sv
// Round-robin share of one truncation datapath between two requesters, with a
// 2-entry id-tagged output FIFO and per-requester wrapping acceptance counters.
module trunc_arbiter
   import trunc_pkg::*;
#(
   parameter int DATA_W = trunc_pkg::DATA_W,
   parameter int LEN_W  = trunc_pkg::LEN_W,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [LEN_W-1:0]  req0_len,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [LEN_W-1:0]  req1_len,
   input  logic [DATA_W-1:0] req1_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_id,
   output logic [15:0]       grant_cnt0,
   output logic [15:0]       grant_cnt1
);

   logic [1:0]  count_q, count_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        last_grant_q, last_grant_d;
   logic [15:0] cnt0_q, cnt0_d;
   logic [15:0] cnt1_q, cnt1_d;
   entry_t      fifo_q [DEPTH];

   logic        full;
   logic        rdy0, rdy1;
   logic        acc0, acc1;
   logic        push, pop;
   len_t        win_len;
   data_t       win_data;
   data_t       win_masked;
   entry_t      push_entry;
   entry_t      head;

   assign full = (count_q == DEPTH[1:0]);

   // Readiness depends only on valids, the pointer and the registered count,
   // so there is no combinational path from out_ready back to the producers.
   always_comb begin
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      if (rst_n && !full) begin
         if (req0_valid && (!req1_valid || last_grant_q)) rdy0 = 1'b1;
         if (req1_valid && (!req0_valid || !last_grant_q)) rdy1 = 1'b1;
      end
   end

   assign req0_ready = rdy0;
   assign req1_ready = rdy1;
   assign acc0       = req0_valid && rdy0;
   assign acc1       = req1_valid && rdy1;
   assign push       = acc0 || acc1;
   assign pop        = out_valid && out_ready;

   assign win_len  = acc1 ? req1_len  : req0_len;
   assign win_data = acc1 ? req1_data : req0_data;

   trunc_mask #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_mask (
      .len_i  (win_len),
      .data_i (win_data),
      .data_o (win_masked)
   );

   always_comb begin
      push_entry      = '0;
      push_entry.data = win_masked;
      push_entry.id   = acc1;
   end

   always_comb begin
      count_d      = count_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      last_grant_d = last_grant_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (push) begin
         wr_ptr_d     = ~wr_ptr_q;
         last_grant_d = acc1;
      end
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (acc0) cnt0_d   = cnt0_q + 16'd1;
      if (acc1) cnt1_d   = cnt1_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q      <= 2'd0;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         last_grant_q <= 1'b1;
         cnt0_q       <= 16'd0;
         cnt1_q       <= 16'd0;
      end else begin
         count_q      <= count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         last_grant_q <= last_grant_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   // Storage carries no reset; stale contents are hidden by gating on out_valid.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= push_entry;
   end

   assign head       = fifo_q[rd_ptr_q];
   assign out_valid  = (count_q != 2'd0);
   assign out_data   = out_valid ? head.data : '0;
   assign out_id     = out_valid ? head.id   : 1'b0;
   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;

endmodule

// File: doc/trunc_arbiter.md
# trunc_arbiter

Shares one low-bit truncation datapath between two requesters. Each request carries a 32-bit word and a 5-bit length. The result keeps only the low `len` bits of the word, and bit 31 is always cleared. The block does round-robin arbitration, at most one grant per cycle, and buffers results in a 2-entry output FIFO tagged with the requester id, so it sits between two producer pipelines and a shared consumer.

## Interface
- `DATA_W`, 32: datapath width. Only 32 is supported.
- `LEN_W`, 5: length field width, equal to log2(DATA_W).
- `DEPTH`, 2: output FIFO entries. Fixed at 2.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a request.
- `req0_ready` out 1: requester 0 request accepted this cycle.
- `req0_len` in LEN_W: number of low bits to keep.
- `req0_data` in DATA_W: word to truncate.
- `req1_valid`, `req1_ready`, `req1_len`, `req1_data`: same as requester 0, for requester 1.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer takes the head.
- `out_data` out DATA_W: truncated result.
- `out_id` out 1: id of the requester that produced the result.
- `grant_cnt0` out 16: wrapping count of requester 0 acceptances.
- `grant_cnt1` out 16: wrapping count of requester 1 acceptances.

## Operation
- **Mask rule:** `mask[i] = (i < len)` for i in 0..30, and `mask[31] = 0`. Result is `data & mask`.
  - `len = 0` gives 0.
  - `len = 31` gives `data[30:0]`.
- **Acceptance:** a request is accepted when its `valid` and `ready` are both high on a rising edge.
- **Ready:** `ready` is combinational from `valid`, the round-robin pointer and the registered FIFO count only. There is no path from `out_ready`.
- **Arbitration:**
  - FIFO full (count == 2): both `ready` are 0.
  - Only one requester valid: that requester gets `ready`.
  - Both valid: the requester that is not `last_grant` wins.
  - `last_grant` updates to the winner on each accept.
- **Data path:** the winner's len/data go through the mask and are pushed with its id in the same edge.
- **FIFO:** the write pointer, read pointer and 2-bit count are registered.
  - Push and pop on the same edge: count is unchanged.
  - A push is never attempted when full, even if a pop occurs in the same cycle. This avoids a comb `out_ready`→`ready` path.
  - `out_valid = (count != 0)`. `out_data` and `out_id` show the head entry.
- **Counters:** `grant_cntN` increments on each accept from requester N and wraps from 0xFFFF to 0.
- **Reset values:**
  - count = 0, pointers = 0, `last_grant` = 1 (so requester 0 wins first).
  - Counters = 0.
  - `out_valid` = 0, `out_data` = 0, `out_id` = 0.
  - Both `ready` = 0 while `rst_n` is low.
- **Reset mid-operation:** FIFO contents are discarded and no partial output appears.

## Timing
- Latency: accept at edge N puts the result on `out_*` after edge N if the FIFO was empty. Otherwise the result follows the entries already queued.
- Throughput: one result per cycle while `out_ready` stays high. The FIFO stays at count ≤ 1 in steady state, so `ready` never drops.
- Backpressure: with `out_ready` low, two accepts fill the FIFO. `ready` goes low from the next cycle.
- The first `ready` after full appears in the cycle after a pop edge.
- A requester must hold valid/len/data stable until accepted. A dropped `valid` is legal and is simply not granted.
- Asynchronous assert, synchronous deassert is handled externally. The block reacts on the first rising edge with `rst_n` high.

## Structure
- **Package `trunc_pkg`:** `DATA_W`, `LEN_W`, `len_t` (logic [LEN_W-1:0]), `data_t`, and a struct for a FIFO entry `{data_t data; logic id;}`.
- **Sub-module `trunc_mask`:** combinational; inputs len and data, output masked data. It implements the mask rule above and is reused wherever truncation is needed.
- **Top level:** holds the arbiter, FIFO and counters, all in a single `always_ff` domain on `clk`/`rst_n`.

## Test plan
- Reset, then a single req0 with len=8, data=0xDEADBEEF and `out_ready=1` → after 1 edge `out_valid=1`, `out_data=0x000000EF`, `out_id=0`, `grant_cnt0=1`.
- Boundary lengths: len=0 with data 0xFFFFFFFF gives 0x00000000; len=31 gives 0x7FFFFFFF; len=1 with data 0x3 gives 0x1.
- Both requesters valid continuously with `out_ready=1` → grants alternate 0,1,0,1, and after 8 cycles `grant_cnt0=4`, `grant_cnt1=4`.
- `out_ready=0` with both valid → exactly 2 accepts and `ready` low from the third cycle. Raising `out_ready` drains entries in order with ids 0,1; `ready` returns the cycle after the first pop.
- Assert `rst_n` low with 2 entries queued → `out_valid=0`, counters 0, both `ready` 0 immediately. After release the first grant goes to requester 0.
- Drive 65536 req1 accepts → `grant_cnt1` wraps to 0 and `grant_cnt0` is unchanged.
